result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
//   Reader side of the systolic core's result buffer. On a capture pulse it snapshots
//   all 16 accumulated 4x4 results, then streams them one word per handshake over a
//   valid/ready port. Sits between the core's result_buffer bus and the NoC egress.
//   Streams in row-major or column-major (transposed) order.
// PARAMETERS
//   ACCUMULATE  32  width of one result word; must match the core's ACCUMULATE
//   DIM         4   array dimension; ENTRIES = DIM*DIM = 16 words per snapshot
// PORTS
//   clk            in   1            single clock, rising edge
//   reset          in   1            asynchronous, active-low reset
//   capture        in   1            1-cycle request: snapshot result_buffer and start draining
//   col_major      in   1            sampled with capture: 0 = row-major order, 1 = column-major
//   result_buffer  in   16*ACC       entry i = result_buffer[i*ACC +: ACC], i = row*DIM + col
//   out_data       out  ACC          current streamed word
//   out_index      out  4            entry index i of out_data
//   out_valid      out  1            out_data, out_index and out_last are valid
//   out_ready      in   1            downstream accept; transfer when out_valid & out_ready
//   out_last       out  1            high with the final (16th) word
//   busy           out  1            snapshot held / streaming in progress
//   done           out  1            1-cycle pulse after the final transfer
//   overrun        out  1            sticky: capture arrived while busy
// BEHAVIOUR
//   - Reset (async, reset==0): every output is 0, FSM = IDLE, seq count = 0, snapshot = 0.
//     Asserting reset mid-stream drops out_valid at once. The word in flight is lost.
//   - FSM: IDLE -> STREAM on capture. STREAM -> DONE on transfer with seq==15.
//     DONE -> IDLE unconditionally. DONE lasts one cycle, with done=1 and busy=1.
//   - Capture in IDLE at edge N: latch all 16 words and col_major, set seq=0, clear overrun.
//     out_valid=1 from cycle N+1: latency 1 cycle from capture to the first word.
//   - Order for seq k (0..15): row-major idx = k. col_major idx = (k%DIM)*DIM + k/DIM.
//   - out_data = snapshot[idx]. out_index = idx. out_last = (k==15).
//   - Handshake: while out_valid & !out_ready, out_data, out_index and out_last hold stable.
//     Each transfer advances k by 1 at the next edge, so back-to-back ready gives 1 word/cycle.
//   - out_valid never drops in STREAM until the final transfer. It is 0 in IDLE and DONE.
//   - busy=1 in STREAM and DONE.
//   - Capture while busy (including the final-transfer cycle and DONE) is ignored and sets
//     overrun=1. The snapshot is not disturbed.
//   - overrun stays set until reset or the next accepted capture.
//   - Snapshot is taken once at capture. Later result_buffer changes do not affect the stream.
//   - Data is a raw pass-through. No truncation or sign handling; all 16 words are sent.
// STRUCTURE
//   - Shared package nnoc_pkg: DIM, ENTRIES, ACC_W constants, and typedef drain_state_t
//     {IDLE, STREAM, DONE}.
//   - One sub-module drain_index_gen (combinational): maps {k, col_major} -> idx and last.
//   - Top holds the 16xACC snapshot regs, the FSM, seq counter and overrun.
// TESTING
//   1. Fill result_buffer word i = 32'h100+i. Pulse capture with col_major=0, ready held 1.
//      Expect 16 consecutive transfers with data 0x100..0x10F and idx 0..15.
//      out_last on the 16th transfer, done one cycle later, busy low the cycle after.
//   2. Same data, col_major=1. Expect idx sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15,
//      with data 0x100+idx each.
//   3. Drive ready 1,0,0,1 repeating. Data and idx hold during stalls.
//      Still exactly 16 transfers and no duplicates.
//   4. Change result_buffer to all 32'hDEADBEEF right after capture.
//      The stream still carries the captured 0x100.. values.
//   5. Pulse capture at word 5 and again in the DONE cycle. Both are ignored and overrun=1.
//      Then capture in IDLE: overrun clears and a new stream starts.
//   6. Assert reset while idx=7 is stalled. All outputs go to 0 asynchronously.
//      After release a capture restarts from idx 0.

Source files
------------

// File: rtl/nnoc_pkg.sv
// Shared constants and state encoding for the systolic core's NoC-facing blocks.
package nnoc_pkg;

  localparam int DIM     = 4;
  localparam int ENTRIES = DIM * DIM;
  localparam int ACC_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } drain_state_t;

endpackage

// File: rtl/drain_index_gen.sv
// Maps a stream sequence number to a result-buffer entry index, row- or column-major.
module drain_index_gen #(
  parameter int DIM = nnoc_pkg::DIM
) (
  input  logic [3:0] seq_i,
  input  logic       col_major_i,
  output logic [3:0] idx_o,
  output logic       last_o
);

  localparam int ENTRIES = DIM * DIM;

  // Column-major walks down each column: seq k picks row k%DIM of column k/DIM.
  always_comb begin
    if (col_major_i) begin
      idx_o = 4'(((int'(seq_i) % DIM) * DIM) + (int'(seq_i) / DIM));
    end else begin
      idx_o = seq_i;
    end
    last_o = (int'(seq_i) == ENTRIES - 1);
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots the 4x4 accumulated results on capture and streams them over valid/ready.
module result_drain #(
  parameter int ACCUMULATE = nnoc_pkg::ACC_W,
  parameter int DIM        = nnoc_pkg::DIM
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture,
  input  logic                            col_major,
  input  logic [DIM*DIM*ACCUMULATE-1:0]   result_buffer,
  output logic [ACCUMULATE-1:0]           out_data,
  output logic [3:0]                      out_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  import nnoc_pkg::*;

  localparam int ENTRIES_L = DIM * DIM;

  drain_state_t          state_q, state_d;
  logic [3:0]            seq_q, seq_d;
  logic                  col_major_q, col_major_d;
  logic                  overrun_q, overrun_d;
  logic [ACCUMULATE-1:0] snap_q [ENTRIES_L];
  logic [3:0]            idx;
  logic                  last_word;
  logic                  accept;

  drain_index_gen #(.DIM(DIM)) u_index_gen (
    .seq_i       (seq_q),
    .col_major_i (col_major_q),
    .idx_o       (idx),
    .last_o      (last_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      col_major_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      col_major_q <= col_major_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES_L; i++) snap_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < ENTRIES_L; i++) snap_q[i] <= result_buffer[i*ACCUMULATE +: ACCUMULATE];
    end
  end

  // A capture is only honoured in IDLE; anywhere else it just flags overrun.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    col_major_d = col_major_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          accept      = 1'b1;
          state_d     = STREAM;
          seq_d       = '0;
          col_major_d = col_major;
          overrun_d   = 1'b0;
        end
      end
      STREAM: begin
        if (capture) overrun_d = 1'b1;
        if (out_ready) begin
          seq_d = seq_q + 4'd1;
          if (last_word) state_d = DONE;
        end
      end
      DONE: begin
        if (capture) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? snap_q[idx] : '0;
  assign out_index = out_valid ? idx : '0;
  assign out_last  = out_valid & last_word;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: random data and ready patterns against an order model.
module tb_result_drain;

  localparam int ACC = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             capture = 1'b0;
  logic             col_major = 1'b0;
  logic             out_ready = 1'b0;
  logic [16*ACC-1:0] result_buffer;
  logic [ACC-1:0]   out_data;
  logic [3:0]       out_index;
  logic             out_valid, out_last, busy, done, overrun;

  logic [ACC-1:0]   bufWords [16];
  int               checks = 0;
  int               errors = 0;

  int               expIdx[$];
  logic [ACC-1:0]   expData[$];
  int               obsIdx[$];
  logic [ACC-1:0]   obsData[$];
  int               lastCount, lastPos, stallBad;
  bit               timedOut;
  logic             doneSeen, doneBusy, doneValid, idleBusy, idleDone;

  result_drain dut (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .col_major     (col_major),
    .result_buffer (result_buffer),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) result_buffer[i*ACC +: ACC] = bufWords[i];
  end

  // Reference order: row-major visits rows outermost, column-major visits columns outermost.
  function automatic void buildExpected(input bit cm);
    expIdx.delete();
    expData.delete();
    for (int outer = 0; outer < 4; outer++) begin
      for (int inner = 0; inner < 4; inner++) begin
        int e;
        e = cm ? (inner * 4 + outer) : (outer * 4 + inner);
        expIdx.push_back(e);
        expData.push_back(bufWords[e]);
      end
    end
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < 16; i++) bufWords[i] = $urandom;
  endtask

  task automatic startCapture(input bit cm);
    col_major = cm;
    capture   = 1'b1;
    buildExpected(cm);
    @(posedge clk); #1;
    capture   = 1'b0;
  endtask

  // Drains one stream: mode 0 ready always, 1 ready 1,0,0,1, 2 random ready.
  task automatic collect(input int mode, input int captureAtK, input bit captureInDone);
    int cycles = 0;
    bit stalled = 1'b0;
    bit finalXfer;
    logic [ACC-1:0] hD;
    logic [3:0] hI;
    logic hL;
    obsIdx.delete();
    obsData.delete();
    lastCount = 0; lastPos = -1; stallBad = 0; timedOut = 1'b0;
    hD = '0; hI = '0; hL = 1'b0;
    forever begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      capture = (captureAtK >= 0) && out_valid && (obsIdx.size() == captureAtK);
      #1;
      finalXfer = 1'b0;
      if (out_valid) begin
        if (stalled && (out_data !== hD || out_index !== hI || out_last !== hL)) stallBad++;
        if (out_ready) begin
          obsIdx.push_back(int'(out_index));
          obsData.push_back(out_data);
          if (out_last) begin
            lastCount++;
            lastPos = obsIdx.size() - 1;
            finalXfer = 1'b1;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hD = out_data; hI = out_index; hL = out_last;
        end
      end
      @(posedge clk); #1;
      capture = 1'b0;
      cycles++;
      if (finalXfer) break;
      if (cycles > 200) begin
        timedOut = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    capture   = captureInDone;
    #1;
    doneSeen = done; doneBusy = busy; doneValid = out_valid;
    @(posedge clk); #1;
    capture  = 1'b0;
    idleBusy = busy; idleDone = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_last, busy, done, overrun} !== 5'b0 || out_data !== '0 || out_index !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b last=%b busy=%b done=%b ovr=%b data=%h idx=%0d, expected all 0",
               out_valid, out_last, busy, done, overrun, out_data, out_index);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_row_major();
    for (int i = 0; i < 16; i++) bufWords[i] = 32'h100 + i;
    startCapture(1'b0);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL row_first_latency: got valid=%b busy=%b, expected 1 1", out_valid, busy);
    end
    collect(0, -1, 1'b0);
    checks++;
    if (timedOut || obsIdx.size() != 16) begin
      errors++;
      $display("[TB] FAIL row_count: got %0d transfers (timeout=%b), expected 16", obsIdx.size(), timedOut);
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== i || obsData[i] !== 32'h100 + i) begin
        errors++;
        $display("[TB] FAIL row_word%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], i, 32'h100 + i);
      end
    end
    checks++;
    if (lastCount != 1 || lastPos != 15) begin
      errors++;
      $display("[TB] FAIL row_last: got %0d lasts at pos %0d, expected 1 at pos 15", lastCount, lastPos);
    end
    checks++;
    if (doneSeen !== 1'b1 || doneBusy !== 1'b1 || doneValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL row_done_cycle: got done=%b busy=%b valid=%b, expected 1 1 0", doneSeen, doneBusy, doneValid);
    end
    checks++;
    if (idleBusy !== 1'b0 || idleDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL row_back_idle: got busy=%b done=%b, expected 0 0", idleBusy, idleDone);
    end
  endtask

  task automatic test_col_major();
    for (int i = 0; i < 16; i++) bufWords[i] = 32'h100 + i;
    startCapture(1'b1);
    collect(0, -1, 1'b0);
    checks++;
    if (timedOut || obsIdx.size() != 16) begin
      errors++;
      $display("[TB] FAIL col_count: got %0d transfers (timeout=%b), expected 16", obsIdx.size(), timedOut);
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== 32'h100 + expIdx[i]) begin
        errors++;
        $display("[TB] FAIL col_word%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], 32'h100 + expIdx[i]);
      end
    end
  endtask

  task automatic test_stall();
    fillRandom();
    startCapture(1'($urandom_range(0, 1)));
    collect(1, -1, 1'b0);
    checks++;
    if (timedOut || obsIdx.size() != 16 || lastCount != 1) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d transfers, %0d lasts, expected 16 and 1", obsIdx.size(), lastCount);
    end
    checks++;
    if (stallBad != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got %0d unstable stall cycles, expected 0", stallBad);
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL stall_word%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < 16; i++) bufWords[i] = 32'h100 + i;
    startCapture(1'b0);
    for (int i = 0; i < 16; i++) bufWords[i] = 32'hDEADBEEF;
    collect(2, -1, 1'b0);
    checks++;
    if (timedOut || obsIdx.size() != 16) begin
      errors++;
      $display("[TB] FAIL snap_count: got %0d transfers, expected 16", obsIdx.size());
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL snap_word%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
      end
    end
  endtask

  task automatic test_overrun();
    fillRandom();
    startCapture(1'b0);
    fillRandom();
    col_major = 1'b1;
    collect(0, 5, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_set: got overrun=%b, expected 1", overrun);
    end
    checks++;
    if (timedOut || obsIdx.size() != 16 || stallBad != 0) begin
      errors++;
      $display("[TB] FAIL ovr_count: got %0d transfers, expected 16", obsIdx.size());
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL ovr_word%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
      end
    end
    startCapture(1'b1);
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || out_index !== 4'd0) begin
      errors++;
      $display("[TB] FAIL ovr_clear: got overrun=%b valid=%b idx=%0d, expected 0 1 0", overrun, out_valid, out_index);
    end
    collect(0, -1, 1'b0);
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL ovr_restart%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int n = 0;
    fillRandom();
    startCapture(1'b0);
    out_ready = 1'b1;
    while (!(out_valid && out_index == 4'd7) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n >= 40 || out_index !== 4'd7 || out_data !== expData[7] || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_stall_hold: got idx %0d data %h valid=%b, expected idx 7 data %h valid 1",
               out_index, out_data, out_valid, expData[7]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, overrun} !== 5'b0 || out_data !== '0 || out_index !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: got valid=%b last=%b busy=%b done=%b ovr=%b data=%h idx=%0d, expected all 0",
               out_valid, out_last, busy, done, overrun, out_data, out_index);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fillRandom();
    startCapture(1'b1);
    collect(2, -1, 1'b0);
    checks++;
    if (timedOut || obsIdx.size() != 16) begin
      errors++;
      $display("[TB] FAIL rst_restart_count: got %0d transfers, expected 16", obsIdx.size());
    end
    for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
      checks++;
      if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL rst_restart%0d: got idx %0d data %h, expected idx %0d data %h",
                 i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      fillRandom();
      startCapture(1'($urandom_range(0, 1)));
      collect(2, -1, 1'b0);
      checks++;
      if (timedOut || obsIdx.size() != 16 || lastPos != 15 || stallBad != 0) begin
        errors++;
        $display("[TB] FAIL b2b_run%0d: got %0d transfers, last at %0d, %0d unstable stalls, expected 16, 15, 0",
                 r, obsIdx.size(), lastPos, stallBad);
      end
      for (int i = 0; i < obsIdx.size() && i < 16; i++) begin
        checks++;
        if (obsIdx[i] !== expIdx[i] || obsData[i] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL b2b_run%0d_word%0d: got idx %0d data %h, expected idx %0d data %h",
                   r, i, obsIdx[i], obsData[i], expIdx[i], expData[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bufWords[i] = '0;
    test_reset();
    test_row_major();
    test_col_major();
    test_stall();
    test_snapshot();
    test_overrun();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
